// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline register with flush, occupancy and stall counter.
// Ports: clk, rst (sync, active-low), flush, in_valid/in_ready/in_data,
//   out_valid/out_ready/out_data, occupancy, stall_cnt, cnt_clr.
module pipe_stage_skid #(
  parameter int DATA_W        = 160,
  parameter int STALL_CNT_W   = 16,
  parameter bit ZERO_ON_EMPTY = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   cnt_clr
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  logic                   r_m_v;
  logic                   r_s_v;
  logic [DATA_W-1:0]      r_m_d;
  logic [DATA_W-1:0]      r_s_d;
  logic [STALL_CNT_W-1:0] r_cnt;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_m_v;
  logic                   w_s_v;
  logic [DATA_W-1:0]      w_m_d;
  logic [DATA_W-1:0]      w_s_d;
  logic [STALL_CNT_W-1:0] w_cnt;

  // in_ready is a pure function of the skid flag
  assign in_ready  = ~r_s_v;
  assign out_valid = r_m_v;
  assign out_data  = r_m_d;
  assign occupancy = {1'b0, r_m_v} + {1'b0, r_s_v};

  assign stall_cnt = r_cnt;

  assign w_push = in_valid & ~r_s_v;
  assign w_pop  = r_m_v & out_ready;

  always_comb begin
    w_m_v = r_m_v;
    w_s_v = r_s_v;
    w_m_d = r_m_d;
    w_s_d = r_s_d;
    if (flush) begin
      w_m_v = 1'b0;
      w_s_v = 1'b0;
      w_m_d = '0;
      w_s_d = '0;
    end else if (!r_m_v) begin
      if (w_push) begin
        w_m_v = 1'b1;
        w_m_d = in_data;
      end else if (ZERO_ON_EMPTY) begin
        w_m_d = '0;
      end
    end else if (w_pop) begin
      if (r_s_v) begin
        w_m_d = r_s_d;
        w_s_v = 1'b0;
        if (ZERO_ON_EMPTY) w_s_d = '0;
      end else if (w_push) begin
        w_m_d = in_data;
      end else begin
        w_m_v = 1'b0;
        if (ZERO_ON_EMPTY) w_m_d = '0;
      end
    end else if (!r_s_v && w_push) begin
      w_s_v = 1'b1;
      w_s_d = in_data;
    end
  end

  always_comb begin
    w_cnt = r_cnt;
    if (cnt_clr) begin
      w_cnt = '0;
    end else if (r_m_v && !out_ready && r_cnt != CNT_MAX) begin
      w_cnt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_m_v <= 1'b0;
      r_s_v <= 1'b0;
      r_m_d <= '0;
      r_s_d <= '0;
      r_cnt <= '0;
    end else begin
      r_m_v <= w_m_v;
      r_s_v <= w_s_v;
      r_m_d <= w_m_d;
      r_s_d <= w_s_d;
      r_cnt <= w_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed + short random bench for pipe_stage_skid.
// A queue scoreboard tracks payload order; a small model tracks the counter.
module tb_pipe_stage_skid;

  localparam int DW = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic          cnt_clr;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb[$];
  int            m_cnt = 0;
  bit            known = 1'b0;

  pipe_stage_skid #(
    .DATA_W(DW), .STALL_CNT_W(CW), .ZERO_ON_EMPTY(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle, advance the model, then cross the edge.
  task automatic cycle();
    int n;
    @(negedge clk);
    n = sb.size();
    if (known) begin
      chk("occ", {30'd0, occupancy}, n);
      chk("out_valid", {31'd0, out_valid}, (n != 0) ? 1 : 0);
      chk("in_ready", {31'd0, in_ready}, (n < 2) ? 1 : 0);
      chk("out_data", {16'd0, out_data}, (n != 0) ? {16'd0, sb[0]} : 0);
      chk("stall_cnt", {29'd0, stall_cnt}, m_cnt);
    end
    if (!rst) begin
      sb.delete();
      m_cnt = 0;
    end else begin
      if (n > 0 && out_ready) void'(sb.pop_front());
      if (in_valid && n < 2) sb.push_back(in_data);
      if (flush) sb.delete();
      if (cnt_clr) m_cnt = 0;
      else if (n > 0 && !out_ready && m_cnt < 7) m_cnt++;
    end
    @(posedge clk);
    #1;
    if (!rst) known = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b1; in_data = 16'hA5; out_ready = 1'b0;
    // reset / idle
    cycle(); cycle();
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data", {16'd0, out_data}, 0);
    chk("rst_ready", {31'd0, in_ready}, 1);
    chk("rst_occ", {30'd0, occupancy}, 0);
    chk("rst_cnt", {29'd0, stall_cnt}, 0);
    rst = 1'b1; in_valid = 1'b0;
    cycle();
    // streaming
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 16'h1; cycle();
    chk("stream1", {16'd0, out_data}, 32'h1);
    in_data = 16'h2; cycle();
    chk("stream2", {16'd0, out_data}, 32'h2);
    in_data = 16'h3; cycle();
    chk("stream3", {16'd0, out_data}, 32'h3);
    in_valid = 1'b0; cycle(); cycle();
    // backpressure into the skid
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h10; cycle();
    in_data = 16'h11; cycle();
    chk("bp_occ", {30'd0, occupancy}, 2);
    chk("bp_ready", {31'd0, in_ready}, 0);
    in_data = 16'h12; cycle();
    in_valid = 1'b0; cycle();
    out_ready = 1'b1;
    cycle();
    chk("drain1", {16'd0, out_data}, 32'h11);
    cycle();
    chk("drain_empty", {31'd0, out_valid}, 0);
    cycle();
    // saturation with a full buffer, then flush
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h20; cycle();
    in_data = 16'h21; cycle();
    in_valid = 1'b0;
    repeat (10) cycle();
    chk("sat", {29'd0, stall_cnt}, 7);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h77;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_occ", {30'd0, occupancy}, 0);
    chk("fl_valid", {31'd0, out_valid}, 0);
    chk("fl_data", {16'd0, out_data}, 0);
    chk("fl_cnt", {29'd0, stall_cnt}, 7);
    cycle();
    // clear while stalled
    in_valid = 1'b1; in_data = 16'h30; cycle();
    in_valid = 1'b0; cycle(); cycle();
    cnt_clr = 1'b1; cycle();
    cnt_clr = 1'b0;
    chk("clr", {29'd0, stall_cnt}, 0);
    cycle();
    chk("resume", {29'd0, stall_cnt}, 1);
    out_ready = 1'b1; cycle(); cycle();
    // random traffic
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data = 16'($urandom);
      cnt_clr = ($urandom_range(0, 15) == 0);
      flush = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush = 1'b0; cnt_clr = 1'b0;
    // reset during a flush with a full buffer
    out_ready = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_data = 16'h40; cycle();
    in_data = 16'h41; cycle();
    cycle();
    chk("pre_rst_occ", {30'd0, occupancy}, 2);
    rst = 1'b0; flush = 1'b1;
    cycle();
    chk("mr_valid", {31'd0, out_valid}, 0);
    chk("mr_data", {16'd0, out_data}, 0);
    chk("mr_ready", {31'd0, in_ready}, 1);
    chk("mr_occ", {30'd0, occupancy}, 0);
    chk("mr_cnt", {29'd0, stall_cnt}, 0);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed EX/MEM-style pipeline register.
- Carries an opaque DATA_W-bit payload between two pipeline stages using a valid/ready handshake, a 2-entry skid buffer and a flush.
- Adds backpressure without a combinational ready path, occupancy reporting and a saturating stall counter.
- Instantiated between any two stages, e.g. EX→MEM with the full EX bundle (ALU result, rd, control, CSR and exception fields) packed into in_data.

Parameters:
- DATA_W, 160, payload width in bits (≥1).
- STALL_CNT_W, 16, width of the stall-cycle counter (≥1).
- ZERO_ON_EMPTY, 1, 1 = out_data reads all-zero whenever out_valid=0; 0 = out_data holds its last value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  squash both entries at this clock edge.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  block can accept; depends only on registered state.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main entry payload.
- occupancy  out  2  number of valid entries, 0..2.
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0.
- cnt_clr  in  1  clear stall_cnt.

Behaviour:
- Storage: main entry (m_v, m_d) drives the outputs; skid entry (s_v, s_d).
- Outputs: out_valid=m_v, out_data=m_d, in_ready=!s_v, occupancy=m_v+s_v.
- Transfer definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- Reset (rst=0 at edge): m_v=s_v=0, m_d=s_d=0, stall_cnt=0. After reset, out_valid=0, in_ready=1, occupancy=0, out_data=0. Reset overrides flush, push and cnt_clr.
- Flush (rst=1, flush=1): m_v=s_v=0, m_d=s_d=0. A push in the same cycle is discarded; a pop in the same cycle completes (downstream has sampled it). stall_cnt is unaffected by flush.
- Normal update (rst=1, flush=0), evaluated in order:
  - m_v=0: a push loads main (latency 1: data is on out_data the cycle after the push).
  - m_v=1, pop, s_v=0: a push loads main, otherwise main empties.
  - m_v=1, pop, s_v=1: skid moves to main and s_v clears. No push is possible because in_ready=0.
  - m_v=1, no pop, s_v=0: a push loads skid, so in_ready=0 on the next cycle.
  - m_v=1, no pop, s_v=1: hold.
- Ordering: strict FIFO; no payload is lost or duplicated while flush=0.
- Throughput: 1 payload per cycle when out_ready=1 continuously.
- ZERO_ON_EMPTY=1: m_d is written 0 whenever main becomes or stays empty. s_d is written 0 when skid empties.
- ZERO_ON_EMPTY=0: vacated data registers keep their values.
- Stall counter:
  - Increments by 1 on each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^STALL_CNT_W−1.
  - cnt_clr=1 loads 0 and wins over increment.
- Invariants:
  - s_v=1 implies m_v=1.
  - occupancy never reaches 3.
  - in_ready has no combinational path from out_ready or in_valid.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst=0 for 2 cycles with in_valid=1, in_data=0xA5.
  - Required: out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.
- Streaming:
  - Stimulus: out_ready=1; push 0x1,0x2,0x3 on consecutive cycles.
  - Required: out_data shows 0x1,0x2,0x3 one cycle later each, out_valid held 1, in_ready always 1, occupancy ≤1.
- Backpressure/skid:
  - Stimulus: push 0x10 then 0x11 with out_ready=0.
  - Required: occupancy=2, in_ready=0, stall_cnt increments each cycle.
  - Stimulus: raise out_ready.
  - Required: pops 0x10, then 0x11, then out_valid=0.
- Flush mid-operation:
  - Stimulus: occupancy=2; assert flush with in_valid=1, in_data=0x77.
  - Required next cycle: occupancy=0, out_valid=0, out_data=0, in_ready=1, stall_cnt unchanged, 0x77 never appears.
- Counter saturation/clear:
  - Stimulus: STALL_CNT_W=3; stall for 10 cycles.
  - Required: stall_cnt=7.
  - Stimulus: cnt_clr=1 while still stalled.
  - Required: stall_cnt=0 next cycle, then resumes counting.
- Mid-operation reset:
  - Stimulus: rst=0 while occupancy=2 and flush=1.
  - Required: all outputs at reset values on the next cycle.
